// File: rtl/pam_prod_accum_pkg.sv
// Shared types and helpers for the product accumulator and its adder.
package pam_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } pam_acc_state_e;

    localparam int PAM_PROD_W = 16;

    // All-ones value of an acc_w-bit accumulator; callers truncate to their width.
    function automatic logic [63:0] sat_max(input int unsigned acc_w);
        return (64'd1 << acc_w) - 64'd1;
    endfunction

endpackage

// File: rtl/pam_prod_accum_sat_add.sv
// Combinational unsigned adder with optional clamp to the accumulator maximum.
module pam_sat_add
    import pam_pkg::*;
#(
    parameter int ACC_W    = 24,
    parameter bit SATURATE = 1'b1
) (
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    output logic [ACC_W-1:0] sum,
    output logic             ovf
);

    localparam logic [ACC_W-1:0] MAX_VAL = ACC_W'(sat_max(ACC_W));

    logic [ACC_W:0] full;

    // ovf reports the raw carry in both modes; only the sum depends on SATURATE
    always_comb begin
        full = {1'b0, a} + {1'b0, b};
        ovf  = full[ACC_W];
        sum  = (SATURATE && full[ACC_W]) ? MAX_VAL : full[ACC_W-1:0];
    end

endmodule

// File: rtl/pam_prod_accum.sv
// Sums a stream of multiplier products into per-vector dot-product results
// held in a one-entry output register with valid/ready on both sides.
module pam_prod_accum
    import pam_pkg::*;
#(
    parameter int PROD_W    = PAM_PROD_W,
    parameter int ACC_W     = 24,
    parameter int MAX_TERMS = 256,
    parameter int CNT_W     = 9,
    parameter int SATURATE  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_sat
);

    localparam logic [CNT_W-1:0] TERM_LIMIT = CNT_W'(MAX_TERMS);
    localparam bit               SAT_EN     = (SATURATE != 0);

    pam_acc_state_e   state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             sat;

    logic             acc_fire;
    logic             out_fire;
    logic [ACC_W-1:0] add_b;
    logic [ACC_W-1:0] nsum;
    logic             ovf;
    logic [CNT_W-1:0] cnt_next;
    logic             sat_next;
    logic             close;

    assign in_ready  = (state == ACCUM) || out_ready;
    assign out_valid = (state == HOLD);
    assign acc_fire  = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    // acc/cnt/sat are always clear while in HOLD, so a beat accepted there
    // seeds a fresh vector through the same add path.
    always_comb begin
        add_b    = acc_fire ? ACC_W'(in_prod) : '0;
        cnt_next = cnt + CNT_W'(1);
        sat_next = sat || (SAT_EN && ovf);
        close    = in_last || (cnt_next == TERM_LIMIT);
    end

    pam_sat_add #(
        .ACC_W   (ACC_W),
        .SATURATE(SAT_EN)
    ) u_add (
        .a  (acc),
        .b  (add_b),
        .sum(nsum),
        .ovf(ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            sat       <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            out_sat   <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (acc_fire) begin
                        if (close) begin
                            out_sum   <= nsum;
                            out_count <= cnt_next;
                            out_sat   <= sat_next;
                            acc       <= '0;
                            cnt       <= '0;
                            sat       <= 1'b0;
                            state     <= HOLD;
                        end else begin
                            acc <= nsum;
                            cnt <= cnt_next;
                            sat <= sat_next;
                        end
                    end
                end
                HOLD: begin
                    if (acc_fire) begin
                        if (close) begin
                            out_sum   <= nsum;
                            out_count <= cnt_next;
                            out_sat   <= sat_next;
                        end else begin
                            acc   <= nsum;
                            cnt   <= cnt_next;
                            sat   <= sat_next;
                            state <= ACCUM;
                        end
                    end else if (out_fire) begin
                        state <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_pam_prod_accum.sv
// Self-checking bench for pam_prod_accum: vector table, directed corner cases
// and a randomized handshake run against a sum-per-vector reference model.
module tb_pam_prod_accum;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_prod = '0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready0, in_ready1, in_ready2, in_ready3;
    logic        out_valid0, out_valid1, out_valid2, out_valid3;
    logic [23:0] out_sum0, out_sum3;
    logic [19:0] out_sum1, out_sum2;
    logic [8:0]  out_count0, out_count1, out_count2, out_count3;
    logic        out_sat0, out_sat1, out_sat2, out_sat3;

    int n_checks = 0;
    int n_fail   = 0;

    logic s_ready0, s_ready1;

    typedef struct {
        longint total;
        int     n;
    } vec_t;

    vec_t   exp_q[$];
    bit     model_on = 1'b0;
    longint cur_total = 0;
    int     cur_n = 0;
    int     accepted = 0;
    int     delivered = 0;

    localparam longint MAX20 = 64'd1048575;

    typedef struct {
        int     n;
        int     p[4];
        longint e_sum;
        int     e_cnt;
    } vec_rec_t;

    vec_rec_t tbl[4];

    always #5 clk = ~clk;

    pam_prod_accum u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .in_prod(in_prod), .in_last(in_last), .out_valid(out_valid0),
        .out_ready(out_ready), .out_sum(out_sum0), .out_count(out_count0),
        .out_sat(out_sat0)
    );

    pam_prod_accum #(.ACC_W(20), .MAX_TERMS(32), .SATURATE(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .in_prod(in_prod), .in_last(in_last), .out_valid(out_valid1),
        .out_ready(out_ready), .out_sum(out_sum1), .out_count(out_count1),
        .out_sat(out_sat1)
    );

    pam_prod_accum #(.ACC_W(20), .MAX_TERMS(32), .SATURATE(0)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_prod(in_prod), .in_last(in_last), .out_valid(out_valid2),
        .out_ready(out_ready), .out_sum(out_sum2), .out_count(out_count2),
        .out_sat(out_sat2)
    );

    pam_prod_accum #(.MAX_TERMS(4)) u3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready3),
        .in_prod(in_prod), .in_last(in_last), .out_valid(out_valid3),
        .out_ready(out_ready), .out_sum(out_sum3), .out_count(out_count3),
        .out_sat(out_sat3)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called just after a falling edge: apply inputs, sample the handshake,
    // update the reference model, then wait through the rising edge.
    task automatic drive(input logic v, input logic [15:0] p, input logic l, input logic r);
        vec_t e;
        in_valid  = v;
        in_prod   = p;
        in_last   = l;
        out_ready = r;
        #1;
        s_ready0 = in_ready0;
        s_ready1 = in_ready1;
        if (model_on && !rst) begin
            check("rnd_out_valid", {63'd0, out_valid1}, {63'd0, exp_q.size() != 0});
            check("rnd_in_ready", {63'd0, in_ready1}, {63'd0, (exp_q.size() == 0) || r});
            check("rnd_ready_match", {63'd0, in_ready2}, {63'd0, in_ready1});
            if (out_valid1 && r && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("rnd_sat_sum", 64'(out_sum1), (e.total > MAX20) ? MAX20 : e.total);
                check("rnd_sat_flag", {63'd0, out_sat1}, {63'd0, e.total > MAX20});
                check("rnd_sat_count", 64'(out_count1), 64'(e.n));
                check("rnd_wrap_sum", 64'(out_sum2), e.total % (MAX20 + 1));
                check("rnd_wrap_flag", {63'd0, out_sat2}, 64'd0);
                check("rnd_wrap_count", 64'(out_count2), 64'(e.n));
                delivered += int'(out_count1);
            end
            if (v && in_ready1) begin
                cur_total += longint'(p);
                cur_n++;
                accepted++;
                if (l || cur_n == 32) begin
                    exp_q.push_back('{cur_total, cur_n});
                    cur_total = 0;
                    cur_n = 0;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 16'd0, 1'b0, 1'b0);
        rst = 1'b0;
        exp_q.delete();
        cur_total = 0;
        cur_n = 0;
        accepted = 0;
        delivered = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic        pend;
        logic        pv, pl, pr;
        logic [15:0] pp;

        tbl[0].n = 3; tbl[0].p = '{65025, 100, 7, 0};         tbl[0].e_sum = 65132;  tbl[0].e_cnt = 3;
        tbl[1].n = 1; tbl[1].p = '{5, 0, 0, 0};               tbl[1].e_sum = 5;      tbl[1].e_cnt = 1;
        tbl[2].n = 2; tbl[2].p = '{0, 0, 0, 0};               tbl[2].e_sum = 0;      tbl[2].e_cnt = 2;
        tbl[3].n = 4; tbl[3].p = '{65535, 65535, 65535, 65535}; tbl[3].e_sum = 262140; tbl[3].e_cnt = 4;

        @(negedge clk);
        do_reset();
        drive(1'b0, 16'd0, 1'b0, 1'b0);

        check("reset_out_valid", {63'd0, out_valid0}, 64'd0);
        check("reset_out_sum", 64'(out_sum0), 64'd0);
        check("reset_out_count", 64'(out_count0), 64'd0);
        check("reset_out_sat", {63'd0, out_sat0}, 64'd0);
        check("reset_in_ready", {63'd0, s_ready0}, 64'd1);

        // Reset in the middle of a vector discards the partial sum.
        drive(1'b1, 16'd10, 1'b0, 1'b1);
        drive(1'b1, 16'd20, 1'b0, 1'b1);
        drive(1'b1, 16'd30, 1'b0, 1'b1);
        rst = 1'b1;
        drive(1'b1, 16'd40, 1'b1, 1'b1);
        rst = 1'b0;
        check("midreset_out_valid", {63'd0, out_valid0}, 64'd0);
        check("midreset_out_sum", 64'(out_sum0), 64'd0);
        drive(1'b1, 16'd5, 1'b1, 1'b1);
        check("midreset_next_valid", {63'd0, out_valid0}, 64'd1);
        check("midreset_next_sum", 64'(out_sum0), 64'd5);
        check("midreset_next_count", 64'(out_count0), 64'd1);

        // Table vectors, back-to-back with out_ready held high.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < tbl[i].n; k++)
                drive(1'b1, 16'(tbl[i].p[k]), k == tbl[i].n - 1, 1'b1);
            check($sformatf("tbl%0d_valid", i), {63'd0, out_valid0}, 64'd1);
            check($sformatf("tbl%0d_sum", i), 64'(out_sum0), 64'(tbl[i].e_sum));
            check($sformatf("tbl%0d_count", i), 64'(out_count0), 64'(tbl[i].e_cnt));
            check($sformatf("tbl%0d_sat", i), {63'd0, out_sat0}, 64'd0);
        end
        drive(1'b0, 16'd0, 1'b0, 1'b1);
        check("tbl_drain_valid", {63'd0, out_valid0}, 64'd0);

        // Saturation versus wrap on a 20-bit accumulator.
        do_reset();
        for (int k = 0; k < 17; k++)
            drive(1'b1, 16'd65025, k == 16, 1'b1);
        check("sat_sum", 64'(out_sum1), 64'd1048575);
        check("sat_flag", {63'd0, out_sat1}, 64'd1);
        check("sat_count", 64'(out_count1), 64'd17);
        check("wrap_sum", 64'(out_sum2), 64'd56849);
        check("wrap_flag", {63'd0, out_sat2}, 64'd0);
        check("wrap_count", 64'(out_count2), 64'd17);

        // Backpressure: pending result stalls input, then releases with a 1-term vector.
        do_reset();
        drive(1'b1, 16'd3, 1'b1, 1'b1);
        check("bp_first_sum", 64'(out_sum0), 64'd3);
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 16'd9, 1'b1, 1'b0);
            check("bp_in_ready", {63'd0, s_ready0}, 64'd0);
            check("bp_hold_valid", {63'd0, out_valid0}, 64'd1);
            check("bp_hold_sum", 64'(out_sum0), 64'd3);
        end
        drive(1'b1, 16'd9, 1'b1, 1'b1);
        check("bp_release_ready", {63'd0, s_ready0}, 64'd1);
        check("bp_next_valid", {63'd0, out_valid0}, 64'd1);
        check("bp_next_sum", 64'(out_sum0), 64'd9);
        check("bp_next_count", 64'(out_count0), 64'd1);

        // MAX_TERMS=4 forces a close before in_last.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 16'd1, k == 5, 1'b1);
            if (k == 3) begin
                check("max_first_valid", {63'd0, out_valid3}, 64'd1);
                check("max_first_sum", 64'(out_sum3), 64'd4);
                check("max_first_count", 64'(out_count3), 64'd4);
            end else if (k == 4) begin
                check("max_mid_valid", {63'd0, out_valid3}, 64'd0);
            end else if (k == 5) begin
                check("max_second_valid", {63'd0, out_valid3}, 64'd1);
                check("max_second_sum", 64'(out_sum3), 64'd2);
                check("max_second_count", 64'(out_count3), 64'd2);
            end
        end

        // Randomized traffic; the upstream holds an unaccepted beat unchanged.
        do_reset();
        model_on = 1'b1;
        pend = 1'b0;
        pv = 1'b0; pl = 1'b0; pp = '0;
        for (int i = 0; i < 3000; i++) begin
            if (!pend) begin
                pv = ($urandom_range(0, 9) < 7);
                pp = ($urandom_range(0, 1) == 1) ? 16'(65025 - $urandom_range(0, 255)) : 16'($urandom);
                pl = ($urandom_range(0, 11) == 0);
            end
            pr = ($urandom_range(0, 9) < 6);
            drive(pv, pp, pl, pr);
            pend = pv && !s_ready1;
        end
        for (int i = 0; i < 10; i++)
            drive(1'b0, 16'd0, 1'b0, 1'b1);
        model_on = 1'b0;
        check("rnd_queue_empty", 64'(exp_q.size()), 64'd0);
        check("rnd_products_once", 64'(delivered + cur_n), 64'(accepted));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
